note_display_ctrl: RTL and testbench
====================================

# note_display_ctrl

Frame-synchronous scheduler that decides which of the 18 synth notes are drawn as key boxes on the 640x480 VGA screen. It snapshots the note vector once per frame during vertical blanking and runs a sequential scan that commits a tear-free lit-note mask. A registered per-pixel hit test then tells the colour stage whether the current pixel lies inside a lit box, and which note owns it. It sits between the note source and the VGA pixel/colour generator, in the 25 MHz pixel clock domain.

## Interface
Parameters:
- X0, 160: x centre of note 0's box, in pixel counter units.
- Y0, 400: y centre of every box.
- PITCH, 32: x spacing between adjacent note centres.
- HALF, 10: box half-size. Inside means strictly `c-HALF < p < c+HALF`.
- MAX_BOXES, 18: maximum number of lit notes per frame. Lowest note indices win.
- HOLD_FRAMES, 8: frames a released note stays lit. Used only with hold compiled in; range 1..15.

Ports:
- clk, in, 1: pixel clock (25 MHz).
- reset, in, 1: synchronous, active-high.
- note, in, 18: live note-active vector.
- frame_start, in, 1: one-cycle pulse at start of vertical blanking.
- pix_x, in, 10: current horizontal counter.
- pix_y, in, 10: current vertical counter.
- lit, out, 18: committed lit-note mask.
- busy, out, 1: scan in progress.
- commit, out, 1: one-cycle pulse when `lit` updates.
- frame_miss, out, 1: sticky flag; a frame_start arrived while busy.
- pix_on, out, 1: registered; the pixel is inside a lit box.
- pix_note, out, 5: registered; lowest note index hit (0 when pix_on=0).

## Operation
- States: IDLE and SCAN.
- IDLE, frame_start=1:
  - note_snap <= note.
  - idx <= 0, count <= 0, shadow <= 0.
  - Go to SCAN.
- SCAN processes one note per cycle, at index idx:
  - Compute candidate per the Configuration section.
  - If candidate and count < MAX_BOXES: shadow[idx] <= 1 and count++.
  - idx++.
- SCAN at idx==17:
  - Process note 17.
  - lit <= final shadow (including bit 17).
  - commit <= 1 for one cycle.
  - Go to IDLE.
- frame_start while in SCAN: ignored and the scan continues; frame_miss <= 1. frame_miss clears only on reset.
- Box centre for note k: cx = X0 + k*PITCH, cy = Y0.
- Hit-test arithmetic:
  - Use 11-bit unsigned values.
  - A low bound c-HALF that would be negative is treated as -1, so pixel 0 qualifies.
  - No wrap-around.
- Hit test each cycle: hit[k] = lit[k] & inbox_x(k) & inbox_y.
  - pix_on <= |hit.
  - pix_note <= priority-encoded lowest k with hit[k] set.
- The pixel path always uses committed `lit`, never `shadow`. A mid-frame note change is invisible until the next commit.
- Reset, including mid-scan:
  - All outputs, lit, shadow, note_snap, count, idx and hold counters go to 0.
  - State goes to IDLE.
  - Any partial scan is discarded.

## Timing
- frame_start sampled high at edge E: busy is high from E+1 through E+18, exactly 18 cycles.
- Edge E+18 updates `lit`. commit is high for the cycle after E+18. busy is low from E+19.
- A frame_start exactly on edge E+18 is a miss, since the state is still SCAN. A frame_start one cycle later is accepted.
- Pixel path latency: 1 cycle. pix_on and pix_note reflect pix_x/pix_y and lit as sampled at the previous edge.
- `note` is sampled only at the accepting edge. It has no other timing requirement.

## Configuration
- Macro: NOTE_DISPLAY_HOLD_EN.
- Defined:
  - Each note has a 4-bit hold counter hc[k], updated only when note k is scanned.
  - If note_snap[k] = 1: hc[k] <= HOLD_FRAMES and the note is a candidate.
  - Else if hc[k] != 0: hc[k] <= hc[k] - 1 and the note is a candidate.
  - Else: not a candidate.
  - Net effect: a released note stays lit for HOLD_FRAMES further frames.
- Undefined: candidate = note_snap[k]. No counters are synthesized.

## Test plan
- Reset, then note=18'h00009, one frame_start:
  - busy is high for 18 cycles.
  - commit pulses once.
  - lit=18'h00009.
- lit bit 0 set, sweeping pix_y=400:
  - pix_on=1, pix_note=0 one cycle after pix_x = 151..169.
  - pix_on=0 at pix_x = 150 and 170.
- MAX_BOXES=2, note=18'h3FFFF: lit=18'h00003. Pixels at note 2's box (pix_x=224, pix_y=400) give pix_on=0.
- frame_start at E, then again at E+5 and at E+18:
  - Both later pulses are ignored.
  - frame_miss=1.
  - A single commit at E+19.
  - A frame_start at E+19 starts a new scan.
- With NOTE_DISPLAY_HOLD_EN and HOLD_FRAMES=2: note[5] high for frame 1, low afterwards. lit[5] is 1 after frames 1, 2 and 3, and 0 after frame 4.
- Reset asserted at E+9 of a scan: all outputs 0 the next cycle, no commit, state IDLE, lit stays 0.

Source files
------------

// File: rtl/note_display_ctrl_if.sv
// note_display_ctrl_if: note source and pixel-path signals of note_display_ctrl
interface note_display_ctrl_if;
  logic [17:0] note;
  logic        frame_start;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [17:0] lit;
  logic        busy;
  logic        commit;
  logic        frame_miss;
  logic        pix_on;
  logic [4:0]  pix_note;
  modport master (
    output note, frame_start, pix_x, pix_y,
    input  lit, busy, commit, frame_miss, pix_on, pix_note
  );
  modport slave (
    input  note, frame_start, pix_x, pix_y,
    output lit, busy, commit, frame_miss, pix_on, pix_note
  );
endinterface

// File: rtl/note_display_ctrl.sv
// note_display_ctrl: per-frame lit-note scan plus registered key-box hit test; NOTE_DISPLAY_HOLD_EN enables release hold
module note_display_ctrl #(
  parameter int X0          = 160,
  parameter int Y0          = 400,
  parameter int PITCH       = 32,
  parameter int HALF        = 10,
  parameter int MAX_BOXES   = 18,
  parameter int HOLD_FRAMES = 8
) (
  input logic clk,
  input logic reset,
  note_display_ctrl_if.slave io
);
  typedef enum logic {IDLE, SCAN} state_t;
  localparam logic [4:0]  MAXB = 5'(MAX_BOXES > 18 ? 18 : MAX_BOXES);
  localparam logic [10:0] H    = 11'(HALF);
  localparam logic [10:0] CY   = 11'(Y0);
  state_t      state_q, state_d;
  logic [17:0] note_snap_q, note_snap_d, shadow_q, shadow_d, lit_q, lit_d, hit;
  logic [4:0]  idx_q, idx_d, count_q, count_d, pix_note_q, pix_note_d;
  logic        commit_q, commit_d, frame_miss_q, frame_miss_d, pix_on_q, pix_on_d;
  logic        cand, take, inbox_y;
  logic [10:0] px, py;
  if (HOLD_FRAMES < 1 || HOLD_FRAMES > 15) begin : g_bad_hold
    $error("HOLD_FRAMES out of range 1..15");
  end
`ifdef NOTE_DISPLAY_HOLD_EN
  logic [3:0] hc_q [18];
  logic [3:0] hc_d [18];
  always_comb begin
    hc_d = hc_q;
    cand = note_snap_q[idx_q] | (hc_q[idx_q] != 4'd0);
    if (state_q == SCAN)
      hc_d[idx_q] = note_snap_q[idx_q] ? 4'(HOLD_FRAMES) : hc_q[idx_q] - {3'b0, cand};
  end
`else
  assign cand = note_snap_q[idx_q];
`endif
  assign take = cand && (count_q < MAXB);
  always_comb begin
    state_d      = state_q;
    note_snap_d  = note_snap_q;
    idx_d        = idx_q;
    count_d      = count_q;
    shadow_d     = shadow_q;
    lit_d        = lit_q;
    commit_d     = 1'b0;
    frame_miss_d = frame_miss_q | (io.frame_start && state_q == SCAN);
    if (state_q == IDLE) begin
      if (io.frame_start) begin
        state_d     = SCAN;
        note_snap_d = io.note;
        idx_d       = 5'd0;
        count_d     = 5'd0;
        shadow_d    = 18'd0;
      end
    end else begin
      shadow_d[idx_q] = take;
      count_d         = count_q + {4'b0, take};
      idx_d           = idx_q + 5'd1;
      if (idx_q == 5'd17) begin
        lit_d    = shadow_d;
        commit_d = 1'b1;
        state_d  = IDLE;
      end
    end
  end
  // bounds compared as p+HALF > c so a negative low bound needs no special case
  assign px      = {1'b0, io.pix_x};
  assign py      = {1'b0, io.pix_y};
  assign inbox_y = (py + H > CY) && (py < CY + H);
  for (genvar g = 0; g < 18; g++) begin : g_box
    localparam logic [10:0] CX = 11'(X0 + g * PITCH);
    assign hit[g] = lit_q[g] & inbox_y & (px + H > CX) & (px < CX + H);
  end
  always_comb begin
    pix_on_d   = |hit;
    pix_note_d = 5'd0;
    for (int k = 17; k >= 0; k--) pix_note_d = hit[k] ? 5'(k) : pix_note_d;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      note_snap_q  <= '0;
      idx_q        <= '0;
      count_q      <= '0;
      shadow_q     <= '0;
      lit_q        <= '0;
      commit_q     <= 1'b0;
      frame_miss_q <= 1'b0;
      pix_on_q     <= 1'b0;
      pix_note_q   <= '0;
`ifdef NOTE_DISPLAY_HOLD_EN
      for (int k = 0; k < 18; k++) hc_q[k] <= '0;
`endif
    end else begin
      state_q      <= state_d;
      note_snap_q  <= note_snap_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      shadow_q     <= shadow_d;
      lit_q        <= lit_d;
      commit_q     <= commit_d;
      frame_miss_q <= frame_miss_d;
      pix_on_q     <= pix_on_d;
      pix_note_q   <= pix_note_d;
`ifdef NOTE_DISPLAY_HOLD_EN
      hc_q         <= hc_d;
`endif
    end
  end
  assign io.lit        = lit_q;
  assign io.busy       = state_q == SCAN;
  assign io.commit     = commit_q;
  assign io.frame_miss = frame_miss_q;
  assign io.pix_on     = pix_on_q;
  assign io.pix_note   = pix_note_q;
endmodule

// File: tb/tb_note_display_ctrl.sv
// tb_note_display_ctrl: scoreboard bench for note_display_ctrl (full box budget and MAX_BOXES=2 instances side by side)
module tb_note_display_ctrl;
  localparam int HF = 2;
`ifdef NOTE_DISPLAY_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  typedef struct {
    bit          busy, commit, miss, on0, on1;
    int          pn0, pn1;
    logic [17:0] lit0, lit1;
  } exp_t;
  typedef struct {
    logic [17:0] l0, l1;
  } lit_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t eq[$];
  lit_t lq[$];
  int remaining = 0;
  bit miss = 1'b0;
  logic [17:0] mlit [2];
  logic [17:0] pend [2];
  int hc [2][18];
  always #5 clk = ~clk;
  note_display_ctrl_if a ();
  note_display_ctrl_if b ();
  assign b.note        = a.note;
  assign b.frame_start = a.frame_start;
  assign b.pix_x       = a.pix_x;
  assign b.pix_y       = a.pix_y;
  note_display_ctrl #(.HOLD_FRAMES(HF)) dut_a (.clk(clk), .reset(reset), .io(a));
  note_display_ctrl #(.MAX_BOXES(2), .HOLD_FRAMES(HF)) dut_b (.clk(clk), .reset(reset), .io(b));
  function automatic void pix(input logic [17:0] l, input int x, input int y, output bit on, output int pn);
    on = 1'b0;
    pn = 0;
    for (int k = 17; k >= 0; k--) begin
      int cx = 160 + 32 * k;
      if (l[k] && x > cx - 10 && x < cx + 10 && y > 390 && y < 410) begin
        on = 1'b1;
        pn = k;
      end
    end
  endfunction
  function automatic logic [17:0] pick(input int i, input logic [17:0] n);
    logic [17:0] r = '0;
    int cnt = 0;
    int maxb = (i == 0) ? 18 : 2;
    for (int k = 0; k < 18; k++) begin
      bit c = n[k];
      if (HOLD) begin
        if (n[k]) hc[i][k] = HF;
        else if (hc[i][k] > 0) begin
          hc[i][k]--;
          c = 1'b1;
        end
      end
      if (c && cnt < maxb) begin
        r[k] = 1'b1;
        cnt++;
      end
    end
    return r;
  endfunction
  initial forever begin
    exp_t e;
    @(posedge clk);
    e = '{default: 0};
    if (reset) begin
      remaining = 0;
      miss = 1'b0;
      mlit = '{18'd0, 18'd0};
      for (int i = 0; i < 2; i++) for (int k = 0; k < 18; k++) hc[i][k] = 0;
    end else begin
      pix(mlit[0], int'(a.pix_x), int'(a.pix_y), e.on0, e.pn0);
      pix(mlit[1], int'(a.pix_x), int'(a.pix_y), e.on1, e.pn1);
      if (remaining > 0) begin
        if (a.frame_start) miss = 1'b1;
        remaining--;
        if (remaining == 0) begin
          mlit = pend;
          e.commit = 1'b1;
          lq.push_back('{pend[0], pend[1]});
        end
      end else if (a.frame_start) begin
        pend[0] = pick(0, a.note);
        pend[1] = pick(1, a.note);
        remaining = 18;
      end
      e.busy = remaining > 0;
      e.miss = miss;
      e.lit0 = mlit[0];
      e.lit1 = mlit[1];
    end
    eq.push_back(e);
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  initial forever begin
    exp_t e;
    lit_t l;
    @(negedge clk);
    if (eq.size() != 0) begin
      e = eq.pop_front();
      chk("busy_a", 32'(a.busy), 32'(e.busy));
      chk("busy_b", 32'(b.busy), 32'(e.busy));
      chk("commit_a", 32'(a.commit), 32'(e.commit));
      chk("commit_b", 32'(b.commit), 32'(e.commit));
      chk("miss_a", 32'(a.frame_miss), 32'(e.miss));
      chk("miss_b", 32'(b.frame_miss), 32'(e.miss));
      chk("pix_on_a", 32'(a.pix_on), 32'(e.on0));
      chk("pix_on_b", 32'(b.pix_on), 32'(e.on1));
      chk("pix_note_a", 32'(a.pix_note), 32'(e.pn0));
      chk("pix_note_b", 32'(b.pix_note), 32'(e.pn1));
      chk("lit_a", 32'(a.lit), 32'(e.lit0));
      chk("lit_b", 32'(b.lit), 32'(e.lit1));
      if (a.commit === 1'b1) begin
        if (lq.size() == 0) chk("commit_queue", 32'd1, 32'd0);
        else begin
          l = lq.pop_front();
          chk("commit_lit_a", 32'(a.lit), 32'(l.l0));
          chk("commit_lit_b", 32'(b.lit), 32'(l.l1));
        end
      end
    end
  end
  task automatic frame(input logic [17:0] n);
    @(negedge clk);
    a.note = n;
    a.frame_start = 1'b1;
    @(negedge clk);
    a.frame_start = 1'b0;
  endtask
  task automatic idle(input int c);
    repeat (c) begin
      @(negedge clk);
      a.pix_x = 10'($urandom_range(140, 720));
      a.pix_y = 10'($urandom_range(385, 415));
    end
  endtask
  initial begin
    a.note = '0;
    a.frame_start = 1'b0;
    a.pix_x = '0;
    a.pix_y = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    frame(18'h00009);
    idle(22);
    a.pix_y = 10'd400;
    for (int x = 145; x <= 175; x++) begin
      @(negedge clk);
      a.pix_x = 10'(x);
    end
    frame(18'h3FFFF);
    idle(22);
    @(negedge clk);
    a.pix_x = 10'd224;
    a.pix_y = 10'd400;
    idle(4);
    frame(18'h0F0F0);
    repeat (4) @(negedge clk);
    a.frame_start = 1'b1;
    @(negedge clk);
    a.frame_start = 1'b0;
    repeat (12) @(negedge clk);
    a.note = 18'h00111;
    a.frame_start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    a.frame_start = 1'b0;
    idle(25);
    frame(18'h00020);
    for (int f = 0; f < 4; f++) begin
      idle(20);
      frame(18'h0);
    end
    idle(22);
    repeat (10) begin
      frame(18'($urandom()) & 18'($urandom()));
      idle($urandom_range(16, 24));
    end
    frame(18'h2AAAA);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle(25);
    frame(18'h3C00F);
    idle(25);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
